// File: rtl/bcd_scan_driver.sv
`default_nettype none
// ============================================================================
// bcd_scan_driver: 8-bit binary to 3-digit BCD (double-dabble) + 3-digit scan.
// Option: ZERO_BLANK_EN blanks leading zeros.  Revision: 1.0
// ============================================================================
module bcd_scan_driver #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] valor,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] D,
  output logic [2:0] AN
);

  localparam int              C_PW        = $clog2(SCAN_DIV);
  localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [11:0]     scratch_q, scratch_d;
  logic [2:0]      step_q, step_d;
  logic            done_q, done_d;
  logic [3:0]      units_q, units_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      hund_q, hund_d;
  logic [C_PW-1:0] presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;

  logic [11:0]     adj_w;
  logic [19:0]     shifted_w;
  logic            blank_tens_w;
  logic            blank_hund_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      done_q    <= 1'b0;
      units_q   <= '0;
      tens_q    <= '0;
      hund_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      step_q    <= step_d;
      done_q    <= done_d;
      units_q   <= units_d;
      tens_q    <= tens_d;
      hund_q    <= hund_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
    end
  end

  // Add-3 correction on every nibble, then one left shift of {scratch, shift}.
  always_comb begin
    adj_w[3:0]   = (scratch_q[3:0]   >= 4'd5) ? scratch_q[3:0]   + 4'd3 : scratch_q[3:0];
    adj_w[7:4]   = (scratch_q[7:4]   >= 4'd5) ? scratch_q[7:4]   + 4'd3 : scratch_q[7:4];
    adj_w[11:8]  = (scratch_q[11:8]  >= 4'd5) ? scratch_q[11:8]  + 4'd3 : scratch_q[11:8];
    shifted_w    = {adj_w, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    step_d    = step_q;
    done_d    = 1'b0;
    units_d   = units_q;
    tens_d    = tens_q;
    hund_d    = hund_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = CONV;
          shift_d   = valor;
          scratch_d = '0;
          step_d    = '0;
        end
      end
      CONV: begin
        shift_d   = shifted_w[7:0];
        scratch_d = shifted_w[19:8];
        step_d    = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = IDLE;
          done_d  = 1'b1;
          units_d = shifted_w[11:8];
          tens_d  = shifted_w[15:12];
          hund_d  = shifted_w[19:16];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == C_PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

`ifdef ZERO_BLANK_EN
  assign blank_hund_w = (hund_q == 4'd0);
  assign blank_tens_w = (hund_q == 4'd0) && (tens_q == 4'd0);
`else
  assign blank_hund_w = 1'b0;
  assign blank_tens_w = 1'b0;
`endif

  always_comb begin
    D  = units_q;
    AN = 3'b110;
    case (idx_q)
      2'd1: begin
        D  = tens_q;
        AN = blank_tens_w ? 3'b111 : 3'b101;
      end
      2'd2: begin
        D  = hund_q;
        AN = blank_hund_w ? 3'b111 : 3'b011;
      end
      default: begin
        D  = units_q;
        AN = 3'b110;
      end
    endcase
  end

  assign busy = (state_q == CONV);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_bcd_scan_driver: directed + random checks of bcd_scan_driver, SCAN_DIV=4.
// Revision: 1.0
// ============================================================================
module tb_bcd_scan_driver;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] valor;
  logic       load;
  logic       busy;
  logic       done;
  logic [3:0] D;
  logic [2:0] AN;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int disp   = 0;

  bcd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .valor (valor),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .AN    (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since reset release; scan position follows from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int digit_of(input int val, input int pos);
    case (pos)
      0:       return val % 10;
      1:       return (val / 10) % 10;
      default: return val / 100;
    endcase
  endfunction

  function automatic logic [2:0] an_of(input int val, input int pos);
    logic [2:0] an;
    an = ~(3'b001 << pos);
`ifdef ZERO_BLANK_EN
    if (pos == 2 && val < 100) an = 3'b111;
    if (pos == 1 && val < 10)  an = 3'b111;
`endif
    return an;
  endfunction

  task automatic scan_now(input string tag);
    int pos;
    pos = (ncyc / SCAN_DIV) % 3;
    check({tag, ".D"},  8'(D),  8'(digit_of(disp, pos)));
    check({tag, ".AN"}, 8'(AN), 8'(an_of(disp, pos)));
  endtask

  task automatic scan_run(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      scan_now(tag);
    end
  endtask

  // One load pulse; checks busy/done across E0..E9 and updates the model at E8.
  task automatic convert(input int val);
    @(negedge clk);
    valor = 8'(val);
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    check("busy_e0", 8'(busy), 8'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        check("busy_conv", 8'(busy), 8'd1);
        check("done_conv", 8'(done), 8'd0);
      end else begin
        disp = val;
        check("busy_e8", 8'(busy), 8'd0);
        check("done_e8", 8'(done), 8'd1);
        scan_now("scan_e8");
      end
    end
    @(negedge clk);
    check("done_e9", 8'(done), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    valor = '0;
    load  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_AN",   8'(AN),   8'b110);
    check("rst_D",    8'(D),    8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    rst_n = 1'b1;
    scan_run("scan_rst", 12);

    convert(255);
    scan_run("scan_255", 13);

    convert(7);
    scan_run("scan_7", 12);

    // load held across a busy conversion: second value accepted at E9
    @(negedge clk);
    valor = 8'd100;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valor = 8'd42;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) check("held_busy", 8'(busy), 8'd1);
      else begin
        disp = 100;
        check("held_done1", 8'(done), 8'd1);
        check("held_busy8", 8'(busy), 8'd0);
        scan_now("held_scan100");
      end
    end
    @(negedge clk);
    load = 1'b0;
    check("held_busy_e9", 8'(busy), 8'd1);
    check("held_done_e9", 8'(done), 8'd0);
    scan_now("held_scan100b");
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) check("held_busy2", 8'(busy), 8'd1);
      else begin
        disp = 42;
        check("held_done2", 8'(done), 8'd1);
      end
    end
    scan_run("scan_42", 12);

    // reset during the 4th conversion cycle of 200
    @(negedge clk);
    valor = 8'd200;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    disp = 0;
    check("mid_busy", 8'(busy), 8'd0);
    check("mid_done", 8'(done), 8'd0);
    check("mid_AN",   8'(AN),   8'b110);
    check("mid_D",    8'(D),    8'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_hold_done", 8'(done), 8'd0);
    end
    rst_n = 1'b1;
    scan_run("scan_after_rst", 12);

    convert(99);
    scan_run("scan_99", 12);
    convert(0);
    scan_run("scan_0", 12);

    for (int i = 0; i < 6; i++) begin
      convert(int'($urandom_range(0, 255)));
      scan_run("scan_rand", 12 + int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Converts an 8-bit binary ULA result to three BCD digits with a sequential shift-add-3 (double-dabble) engine, holds them in a display register, and time-multiplexes them onto one shared seven-segment decoder. It sits directly upstream of `decodificador_7seg`:
- `D` feeds the decoder's 4-bit digit input.
- `AN` drives the active-low common-anode digit enables of a 3-digit display.

## Interface
- `SCAN_DIV`, 1000, clock cycles each digit stays enabled; legal range ≥ 2.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valor`  in  8  unsigned binary value to display.
- `load`  in  1  capture request; honoured only when `busy`=0 at the sampling edge.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; display register updated on this edge.
- `D`  out  4  BCD digit (0–9) of the currently scanned position, to the decoder.
- `AN`  out  3  digit enables, active-low. Bit0 = units, bit1 = tens, bit2 = hundreds.

## Operation
- **Conversion FSM states:**
  - IDLE → CONV when `load`=1 and `busy`=0.
  - CONV → IDLE after 8 shift steps.
- **Capture (IDLE→CONV edge):** `valor` loads into the 8-bit shift register, the 12-bit BCD scratch clears, and the step counter goes to 0.
- **Each CONV cycle:**
  - Every scratch nibble ≥ 5 gets +3.
  - Then {scratch, shift} shifts left 1 bit.
  - The step counter increments.
- **Step 8:** the final shifted scratch is written to the display register (hundreds, tens, units), `done`=1, and the FSM returns to IDLE.
- **`load` during CONV:** ignored and not queued.
- **Display register:** changes only on the `done` edge, so the scan never shows a partial result.
- **Scanner (always running, independent of the FSM):**
  - Prescaler counts 0..SCAN_DIV−1.
  - At SCAN_DIV−1 the prescaler wraps to 0 and the digit index advances 0→1→2→0.
- **Index decode:**
  - Index 0: `D`=units, `AN`=3'b110.
  - Index 1: `D`=tens, `AN`=3'b101.
  - Index 2: `D`=hundreds, `AN`=3'b011.
- **Output range:** `D` is always 0–9; values ≥ 10 are never produced.
- **Arithmetic:** max input 255, so hundreds ≤ 2. The scratch is 12 bits; the top nibble never needs more than 2 bits, so no overflow.

## Timing
- **Reset values (async, while `rst_n`=0):**
  - FSM = IDLE, `busy`=0, `done`=0.
  - Display digits = 0, prescaler = 0, index = 0.
  - `D`=4'd0, `AN`=3'b110.
- **Latency:** `load` is sampled at edge E0; `busy`=1 from E0 to E8. Shift steps occur on E1..E8; the display register updates at E8, with `done`=1 in the cycle after E8 and `busy`=0 from E8.
- **Next load:** the earliest next `load` is accepted at E9. A `load` seen at E1..E8 is dropped.
- **Output decode:** `D`/`AN` are decoded from registered index and display state and change only on the edge that advances the index or writes the display register.
- **Simultaneous events:** a `done` edge coinciding with an index advance shows the new digit of the new position on that edge.
- **Reset mid-conversion:**
  - Aborts immediately with no `done` pulse.
  - The display returns to 000.
  - The first `load` after `rst_n` deasserts is accepted normally.
- **Wrap-around:** index 2 → 0 with no idle gap; each digit is enabled exactly SCAN_DIV cycles per 3·SCAN_DIV period.

## Configuration
- Macro: `ZERO_BLANK_EN`.
- **Defined (leading-zero blanking):**
  - The hundreds position drives `AN` bit2=1 when hundreds=0.
  - The tens position drives `AN` bit1=1 when hundreds=0 and tens=0.
  - Units are never blanked.
  - `D` still carries the digit value and the scan timing is unchanged.
- **Undefined:** all three digits are always enabled in turn, and leading zeros are shown.

## Test plan
All scenarios use SCAN_DIV=4.
- **Reset:** hold `rst_n`=0 → `AN`=110, `D`=0, `busy`=0, `done`=0.
- **Full-scale value:** `valor`=255 with a 1-cycle `load` →
  - `busy` is high 8 cycles and `done` pulses once.
  - The scan shows `D`=5/`AN`=110 for 4 cycles, then 5/101 for 4 cycles, then 2/011 for 4 cycles, then repeats.
- **Small value, `valor`=7:**
  - With `ZERO_BLANK_EN`: `AN` sequence 110, 111, 111 and `D`=7, 0, 0.
  - Without it: `AN` sequence 110, 101, 011 and `D`=7, 0, 0.
- **Load while busy:** `load` with 100, then `valor`=42 with `load` held high through `busy` →
  - The display is 1-0-0 after the first `done`, and the held `load` is sampled at E9 (`busy`=0) and starts a new conversion.
  - After the second `done`, the display is 0-4-2.
- **Reset mid-conversion:** `rst_n` low at the 4th CONV cycle of a 200 conversion → `busy`=0 at once, no `done`, display 000, `AN`=110.
- **Boundary values:**
  - `valor`=99 → units 9, tens 9, hundreds 0.
  - `valor`=0 → all digits 0, and units stay enabled under `ZERO_BLANK_EN`.
